// File: rtl/acc_drain.sv
// Accumulator-bank drain: round-robin reads of non-empty lanes, one word at a
// time onto a valid/ready stream. Define ACC_DRAIN_PERF_EN to build the stall counter.

module acc_drain_lane #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             rem_zero,
  output logic             rem_one
);
  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] rem;

  // Guarded decrement: a lane at zero is never granted, but never wrap regardless
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     rem <= '0;
    else if (load)               rem <= load_val;
    else if (dec && rem != '0)   rem <= rem - ONE;
  end

  assign rem_zero = (rem == '0);
  assign rem_one  = (rem == ONE);
endmodule

module acc_drain #(
  parameter int LANES  = 4,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16,
  parameter int RD_LAT = 1,
  localparam int LW    = $clog2(LANES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [CNT_W-1:0]               cfg_words,
  input  logic [LANES-1:0]               acc_empty,
  input  logic [LANES-1:0][DATA_W-1:0]   accum_o_data,
  output logic [LANES-1:0]               accums_rd_en,
  output logic [DATA_W-1:0]              m_data,
  output logic [LW-1:0]                  m_lane,
  output logic                           m_last,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           busy,
  output logic                           done,
  output logic [31:0]                    perf_stall_cycles
);
  typedef enum logic [2:0] {IDLE, ARB, RD, WAIT, OUT, DONE} state_t;

  localparam logic [LANES-1:0] LANE0     = 1;
  localparam int               WAIT_INIT = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  state_t            state, state_n;
  logic [LW-1:0]     sel, rr_ptr, grant_idx, idx;
  logic              grant_vld;
  logic [1:0]        wait_cnt;
  logic [LANES-1:0]  rem_zero, rem_one, elig, post_zero;
  logic              start_acc, rd_fire, capture, last_flag, hs;

  assign start_acc = (state == IDLE) && start;
  // Re-check empty in the strobe cycle so a lane that emptied since grant is never read
  assign rd_fire   = (state == RD) && !acc_empty[sel];
  assign hs        = m_valid && m_ready;

  genvar l;
  generate
    for (l = 0; l < LANES; l++) begin : g_lane
      acc_drain_lane #(.CNT_W(CNT_W)) u_lane (
        .clk      (clk),
        .rst      (rst),
        .load     (start_acc),
        .load_val (cfg_words),
        .dec      (rd_fire && (sel == LW'(l))),
        .rem_zero (rem_zero[l]),
        .rem_one  (rem_one[l])
      );
      assign elig[l] = !acc_empty[l] && !rem_zero[l];
      // Capture in RD sees the pre-decrement count for the lane being read
      assign post_zero[l] = ((state == RD) && (sel == LW'(l))) ? rem_one[l] : rem_zero[l];
    end
  endgenerate

  assign last_flag = &post_zero;

  // Rotating priority: lowest offset from rr_ptr wins
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr;
    idx       = rr_ptr;
    for (int i = LANES - 1; i >= 0; i--) begin
      idx = rr_ptr + LW'(i);
      if (elig[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign capture = (rd_fire && (RD_LAT == 1)) || ((state == WAIT) && (wait_cnt == '0));

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = (cfg_words == '0) ? DONE : ARB;
      ARB:  if (grant_vld) state_n = RD;
      RD: begin
        if (!rd_fire)          state_n = ARB;
        else if (RD_LAT == 1)  state_n = OUT;
        else                   state_n = WAIT;
      end
      WAIT: if (wait_cnt == '0) state_n = OUT;
      OUT:  if (hs) state_n = m_last ? DONE : ARB;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      rr_ptr   <= '0;
      wait_cnt <= '0;
      m_data   <= '0;
      m_lane   <= '0;
      m_last   <= 1'b0;
      m_valid  <= 1'b0;
    end else begin
      state <= state_n;
      if (start_acc)               rr_ptr <= '0;
      if (state == ARB && grant_vld) sel  <= grant_idx;
      if (rd_fire) begin
        rr_ptr   <= sel + LW'(1);
        wait_cnt <= 2'(WAIT_INIT);
      end else if (state == WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 2'd1;
      end
      if (capture) begin
        m_data  <= accum_o_data[sel];
        m_lane  <= sel;
        m_last  <= last_flag;
        m_valid <= 1'b1;
      end else if (hs) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign accums_rd_en = rd_fire ? (LANE0 << sel) : '0;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

`ifdef ACC_DRAIN_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                 stall_q <= '0;
    else if (start_acc)                                      stall_q <= '0;
    else if (m_valid && !m_ready && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
  end
  assign perf_stall_cycles = stall_q;
`else
  assign perf_stall_cycles = '0;
`endif
endmodule
